// File: rtl/serial_tx_fifo_pkg.sv
// Shared definitions for the buffered serial transmitter:
// register offsets, STATUS layout and transmit FSM encoding.
package serial_tx_fifo_pkg;

    localparam int REG_TXDATA  = 0;
    localparam int REG_STATUS  = 1;
    localparam int REG_DIVISOR = 2;

    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_BUSY_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_CNT_LSB   = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [31:0] status_word(
        input logic       full,
        input logic       empty,
        input logic       busy,
        input logic       ovf,
        input logic [7:0] cnt
    );
        logic [31:0] w;
        w                       = '0;
        w[ST_FULL_BIT]          = full;
        w[ST_EMPTY_BIT]         = empty;
        w[ST_BUSY_BIT]          = busy;
        w[ST_OVF_BIT]           = ovf;
        w[ST_CNT_LSB +: 8]      = cnt;
        return w;
    endfunction

endpackage

// File: rtl/serial_tx_fifo_fifo.sv
// Synchronous FIFO with show-ahead output; a push while full is
// accepted only when a pop frees the slot on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/serial_tx_fifo.sv
// Memory-mapped serial transmitter: TXDATA/STATUS/DIVISOR registers,
// a character FIFO and a start/data/stop serialiser on tx.
module serial_tx_fifo
    import serial_tx_fifo_pkg::*;
#(
    parameter int BASE      = 8,
    parameter int DEPTH     = 4,
    parameter int DATA_BITS = 8,
    parameter int DIV_WIDTH = 16,
    parameter int DIV_RESET = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        rw,
    input  logic [31:0] addr,
    input  logic [31:0] d_in,
    output logic [31:0] d_out,
    output logic        tx,
    output logic        irq
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(DATA_BITS);

    logic                 in_range;
    logic [31:0]          rel;
    logic                 sel_txdata, sel_status, sel_div;
    logic                 wr_txdata, wr_div, rd_status, rd_any;

    logic                 fifo_pop, fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_dout;
    logic [CW-1:0]        fifo_count;

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        idx_q, idx_d, idx_nxt;
    logic [DIV_WIDTH-1:0] per_q, per_d;
    logic [DIV_WIDTH-1:0] reload_q, reload_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 tx_q, tx_d;
    logic                 ovf_q, ovf_d;
    logic                 start_frame;
    logic                 unused_bits;

    assign unused_bits = ^d_in[31:DIV_WIDTH];

    assign in_range = enable && (addr >= 32'(BASE))
                      && (addr <= 32'(BASE + 2));
    assign rel      = addr - 32'(BASE);

    assign sel_txdata = in_range && (rel == 32'(REG_TXDATA));
    assign sel_status = in_range && (rel == 32'(REG_STATUS));
    assign sel_div    = in_range && (rel == 32'(REG_DIVISOR));

    assign wr_txdata = sel_txdata && rw;
    assign wr_div    = sel_div && rw;
    assign rd_status = sel_status && !rw;
    assign rd_any    = in_range && !rw;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (d_in[DATA_BITS-1:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign idx_nxt = idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        per_d       = per_q;
        reload_d    = reload_q;
        tx_d        = tx_q;
        start_frame = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                start_frame = !fifo_empty;
            end
            TX_START: begin
                if (per_q == '0) begin
                    per_d   = reload_q;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = TX_DATA;
                end else begin
                    per_d = per_q - 1'b1;
                end
            end
            TX_DATA: begin
                if (per_q == '0) begin
                    per_d = reload_q;
                    if (idx_q == BW'(DATA_BITS - 1)) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        idx_d = idx_nxt;
                        tx_d  = shift_q[idx_nxt];
                    end
                end else begin
                    per_d = per_q - 1'b1;
                end
            end
            TX_STOP: begin
                if (per_q == '0) begin
                    // back-to-back frames: no idle gap when data waits
                    start_frame = !fifo_empty;
                    state_d     = TX_IDLE;
                end else begin
                    per_d = per_q - 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
        if (start_frame) begin
            shift_d  = fifo_dout;
            reload_d = div_q;
            per_d    = div_q;
            idx_d    = '0;
            tx_d     = 1'b0;
            state_d  = TX_START;
        end
    end

    assign fifo_pop = start_frame;

    always_comb begin
        div_d = div_q;
        ovf_d = ovf_q;
        if (wr_div) begin
            div_d = d_in[DIV_WIDTH-1:0];
        end
        if (rd_status) begin
            ovf_d = 1'b0;
        end
        if (wr_txdata && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        d_out = '0;
        if (rd_any) begin
            unique case (1'b1)
                sel_status: d_out = status_word(fifo_full, fifo_empty,
                                                state_q != TX_IDLE, ovf_q,
                                                8'(fifo_count));
                sel_div:    d_out = 32'(div_q);
                default:    d_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= TX_IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            per_q    <= '0;
            reload_q <= '0;
            div_q    <= DIV_WIDTH'(DIV_RESET);
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            per_q    <= per_d;
            reload_q <= reload_d;
            div_q    <= div_d;
            tx_q     <= tx_d;
            ovf_q    <= ovf_d;
        end
    end

    assign tx  = tx_q;
    assign irq = fifo_empty && (state_q == TX_IDLE);

endmodule

// File: doc/serial_tx_fifo.md
Name: serial_tx_fifo

Overview:
- Memory-mapped serial transmitter; parametrised successor to the current single-register serial sink.
- Sits on the operand bus next to the Mem instances, decoded at BASE.
- Buffers written characters in a DEPTH-entry FIFO and serialises them on a single tx line: start bit, DATA_BITS data bits LSB first, one stop bit. Bit period is programmable.
- Exposes status and divisor registers on the same bus.

Parameters:
- BASE, 8: word address of register block; occupies BASE..BASE+2.
- DEPTH, 4: FIFO entries; power of two, >=2.
- DATA_BITS, 8: character width, 5..8.
- DIV_WIDTH, 16: divisor register width.
- DIV_RESET, 3: divisor value after reset; bit period = divisor+1 clocks.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  bus cycle valid.
- rw  input  1  1 = write, 0 = read.
- addr  input  32  word address.
- d_in  input  32  write data.
- d_out  output  32  read data; the top level tristates it onto the shared data bus.
- tx  output  1  serial line, idle high, registered.
- irq  output  1  high while the FIFO is empty and the FSM is IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: tx=1, d_out=0, irq=1, FIFO count=0, divisor=DIV_RESET, overflow=0, FSM=IDLE.
- Register map (hit = enable && addr in BASE..BASE+2; all other addresses are ignored, d_out=0):
  - BASE+0 TXDATA. Write pushes d_in[DATA_BITS-1:0]. Reads return 0.
  - BASE+1 STATUS, read-only. bit0 full, bit1 empty, bit2 busy (FSM != IDLE), bit3 overflow (sticky), bits[15:8] FIFO count, other bits 0. A read of STATUS clears overflow on that posedge.
  - BASE+2 DIVISOR, read/write. Holds the low DIV_WIDTH bits; upper bits read 0.
- Read timing: d_out is combinational from registered state while enable && !rw && hit, else 0.
- Push when full: data is dropped and overflow is set. Exception: if a pop occurs in the same cycle, the push is accepted and count stays at DEPTH.
- FSM states IDLE, START, DATA, STOP. A bit counter and a period counter of DIV_WIDTH bits.
  - IDLE: if FIFO not empty, pop into the shift register, latch divisor into the period reload, go to START, and drive tx=0 from that edge.
  - START: one period, then DATA with bit index 0.
  - DATA: tx = shift[idx] for one period each; after bit DATA_BITS-1 go to STOP.
  - STOP: tx=1 for one period, then IDLE. If the FIFO is non-empty at the last STOP cycle, go directly to START (pop) with no idle gap.
- Latency: a TXDATA write at posedge N into an empty FIFO with FSM IDLE gives a pop at posedge N+1, with tx low after N+1. A frame lasts (DATA_BITS+2)*(divisor+1) clocks.
- Divisor writes mid-frame take effect at the next frame start only.
- Divisor 0 is legal: 1 clock per bit.
- Reset mid-frame: tx returns high after the reset edge, the FIFO empties, and the in-flight character is lost.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.

Decomposition:
- Shared package: register offsets (TXDATA=0, STATUS=1, DIVISOR=2), STATUS bit positions, and FSM state encoding (2-bit enum).
- One sub-module, sync_fifo (params WIDTH, DEPTH; ports clk, reset, push, pop, din, dout, full, empty, count), same clock and reset.

Test Plan:
- Default divisor 3: write 0x41 to addr 8 -> tx low 4 clocks, then bits 1,0,0,0,0,0,1,0 at 4 clocks each, then high 4 clocks. Total 40 clocks; busy=1 throughout, then irq=1.
- Write 6 characters back-to-back to addr 8 -> first is popped immediately, next 4 fill the FIFO, 6th is dropped. STATUS reads 0x0000_040D (count 4, overflow, busy, full); a second read shows bit3=0.
- Write DIVISOR=0 then 0x55 -> 10-clock frame with alternating bits. Write DIVISOR=7 mid-frame -> the current frame keeps 1 clock/bit; the next queued character uses 8 clocks/bit.
- Two characters queued -> stop bit of the first is followed immediately by the start bit of the second, with no idle clock.
- Assert reset during DATA of 0x41 -> tx=1 and STATUS=0x0000_0002 after the edge; no further tx activity.
- Writes to addr 7 and 11, and read of addr 8 -> no FIFO change, d_out=0. Read of addr 10 returns the divisor.
